// File: rtl/ring_johnson_monitor.sv
// Sequence checker for the 4-bit ring/Johnson counter.
// Tracks step index, lock state, wrap pulses and a saturating error count.
module ring_johnson_monitor #(
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             m,
  input  logic [3:0]       q,
  output logic [2:0]       step,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    LOCKD = 2'd1,
    FAULT = 2'd2
  } st_t;

  st_t             st_q, st_d;
  logic            ref_vld_q, ref_vld_d;
  logic [2:0]      ref_q, ref_d;
  logic [2:0]      acq_q, acq_d;
  logic            m_prev_q;
  logic [2:0]      step_q, step_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic            wrap_q, wrap_d;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;

  logic       legal;
  logic [2:0] idx;
  logic [2:0] nxt;
  logic       is_succ;

  always_comb begin
    legal = 1'b0;
    idx   = 3'd0;
    if (!m) begin
      unique case (q)
        4'b1000: begin legal = 1'b1; idx = 3'd0; end
        4'b0100: begin legal = 1'b1; idx = 3'd1; end
        4'b0010: begin legal = 1'b1; idx = 3'd2; end
        4'b0001: begin legal = 1'b1; idx = 3'd3; end
        default: ;
      endcase
    end else begin
      unique case (q)
        4'b0000: begin legal = 1'b1; idx = 3'd0; end
        4'b1000: begin legal = 1'b1; idx = 3'd1; end
        4'b1100: begin legal = 1'b1; idx = 3'd2; end
        4'b1110: begin legal = 1'b1; idx = 3'd3; end
        4'b1111: begin legal = 1'b1; idx = 3'd4; end
        4'b0111: begin legal = 1'b1; idx = 3'd5; end
        4'b0011: begin legal = 1'b1; idx = 3'd6; end
        4'b0001: begin legal = 1'b1; idx = 3'd7; end
        default: ;
      endcase
    end
  end

  // Ring period is 4, so the successor wraps within two bits.
  always_comb begin
    nxt = ref_q + 3'd1;
    if (!m) nxt[2] = 1'b0;
    is_succ = legal && ref_vld_q && (idx == nxt);
  end

  always_comb begin
    st_d      = st_q;
    ref_vld_d = ref_vld_q;
    ref_d     = ref_q;
    acq_d     = acq_q;
    step_d    = step_q;
    err_d     = 1'b0;
    wrap_d    = 1'b0;
    ecnt_d    = ecnt_q;
    if (m != m_prev_q) begin
      st_d      = ACQ;
      ref_vld_d = legal;
      ref_d     = idx;
      acq_d     = 3'd0;
    end else begin
      unique case (st_q)
        ACQ: begin
          if (!legal) begin
            ref_vld_d = 1'b0;
            acq_d     = 3'd0;
          end else if (is_succ) begin
            ref_d = idx;
            if (acq_q + 3'd1 == 3'(LOCK_CNT)) begin
              st_d   = LOCKD;
              step_d = idx;
              acq_d  = 3'd0;
            end else begin
              acq_d = acq_q + 3'd1;
            end
          end else begin
            ref_vld_d = 1'b1;
            ref_d     = idx;
            acq_d     = 3'd0;
          end
        end
        LOCKD: begin
          if (is_succ) begin
            step_d = idx;
            ref_d  = idx;
            wrap_d = (idx == 3'd0);
          end else begin
            err_d     = 1'b1;
            st_d      = FAULT;
            ref_vld_d = 1'b0;
            if (ecnt_q != {ERR_W{1'b1}}) ecnt_d = ecnt_q + 1'b1;
          end
        end
        FAULT: begin
          st_d      = ACQ;
          ref_vld_d = legal;
          ref_d     = idx;
          acq_d     = 3'd0;
        end
        default: st_d = ACQ;
      endcase
    end
    locked_d = (st_d == LOCKD);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_q      <= ACQ;
      ref_vld_q <= 1'b0;
      ref_q     <= 3'd0;
      acq_q     <= 3'd0;
      m_prev_q  <= 1'b0;
      step_q    <= 3'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      ecnt_q    <= '0;
    end else begin
      st_q      <= st_d;
      ref_vld_q <= ref_vld_d;
      ref_q     <= ref_d;
      acq_q     <= acq_d;
      m_prev_q  <= m;
      step_q    <= step_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign step    = step_q;
  assign locked  = locked_q;
  assign err     = err_q;
  assign wrap    = wrap_q;
  assign err_cnt = ecnt_q;

endmodule
